te_transmission_estimator: RTL and testbench



---
 rtl/te_pkg.sv | 23 ++
 rtl/te_sat_clamp.sv | 17 +
 rtl/te_transmission_estimator.sv | 82 ++++++++
 tb/tb_te_transmission_estimator.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/te_pkg.sv
// Shared widths, defaults and helpers for the transmission estimation path.
// Imported by te_sat_clamp and te_transmission_estimator.
package te_pkg;

    localparam int FC_W   = 8;
    localparam int INVA_W = 10;
    localparam int T_W    = 8;
    localparam int CNT_W  = 20;

    localparam int OM_W = 8;
    localparam int P1_W = FC_W + INVA_W;
    localparam int P2_W = P1_W + OM_W;
    localparam int R_W  = 10;

    localparam logic [OM_W-1:0] OMEGA_DEF  = 8'd243;
    localparam logic [T_W-1:0]  T0_MIN_DEF = 8'd26;

    // Saturate a 10-bit ratio into the 8-bit transmission range.
    function automatic logic [T_W-1:0] sat8(input logic [R_W-1:0] r);
        return (r > R_W'(255)) ? {T_W{1'b1}} : r[T_W-1:0];
    endfunction

endpackage

// File: rtl/te_sat_clamp.sv
// Combinational R -> T: saturate to 8 bits, invert from 255, clamp at T0_MIN.
// Ports: r (10b ratio omega*Fc/A), t (8b transmission, Q0.8).
module te_sat_clamp
    import te_pkg::*;
#(
    parameter logic [T_W-1:0] T0_MIN = T0_MIN_DEF
) (
    input  logic [R_W-1:0] r,
    output logic [T_W-1:0] t
);

    logic [T_W-1:0] tr;

    assign tr = T_W'(255) - sat8(r);
    assign t  = (tr < T0_MIN) ? T0_MIN : tr;

endmodule

// File: rtl/te_transmission_estimator.sv
// Three-stage transmission map T = max(T0_MIN, 255 - omega*Fc/A) with handshake.
// Ports: clk, rst, in_valid/in_ready/Fc/Inv_Ac/in_last, out_valid/out_ready/T/out_last, pix_count.
module te_transmission_estimator
    import te_pkg::*;
#(
    parameter logic [OM_W-1:0] OMEGA  = OMEGA_DEF,
    parameter logic [T_W-1:0]  T0_MIN = T0_MIN_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [FC_W-1:0]   Fc,
    input  logic [INVA_W-1:0] Inv_Ac,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [T_W-1:0]    T,
    output logic              out_last,
    output logic [CNT_W-1:0]  pix_count
);

    logic            v1, v2, v3;
    logic            l1, l2, l3;
    logic [P1_W-1:0] p1;
    logic [P2_W-1:0] p2;
    logic [T_W-1:0]  t_q;
    logic [T_W-1:0]  t_nx;
    logic [CNT_W-1:0] cnt;
    logic            en;

    // Whole pipe moves as one; only a full, unaccepted S3 stalls it.
    assign en       = !v3 || out_ready;
    assign in_ready = en && !rst;

    te_sat_clamp #(
        .T0_MIN (T0_MIN)
    ) u_clamp (
        .r (p2[P2_W-1 -: R_W]),
        .t (t_nx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            v1  <= 1'b0;
            v2  <= 1'b0;
            v3  <= 1'b0;
            l1  <= 1'b0;
            l2  <= 1'b0;
            l3  <= 1'b0;
            p1  <= '0;
            p2  <= '0;
            t_q <= '0;
            cnt <= '0;
        end else begin
            if (en) begin
                v1  <= in_valid;
                l1  <= in_last;
                p1  <= P1_W'(Fc) * P1_W'(Inv_Ac);
                v2  <= v1;
                l2  <= l1;
                p2  <= P2_W'(p1) * P2_W'(OMEGA);
                v3  <= v2;
                l3  <= l2;
                t_q <= t_nx;
            end
            if (v3 && out_ready) begin
                if (l3) begin
                    cnt <= '0;
                end else if (cnt != {CNT_W{1'b1}}) begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

    assign out_valid = v3;
    assign T         = t_q;
    assign out_last  = l3;
    assign pix_count = cnt;

endmodule

// File: tb/tb_te_transmission_estimator.sv
// Scoreboard bench for te_transmission_estimator (default params plus T0_MIN=0).
// Ports: drives clk/rst and both handshakes of two DUT instances.
module tb_te_transmission_estimator;

    localparam int OMEGA_V = 243;
    localparam int T0_V    = 26;

    logic        clk;
    logic        rst;
    logic        in_valid, in_ready, in_last;
    logic [7:0]  Fc;
    logic [9:0]  Inv_Ac;
    logic        out_valid, out_ready, out_last;
    logic [7:0]  T;
    logic [19:0] pix_count;

    logic        iv2, ir2, il2, ov2, or2, ol2;
    logic [7:0]  fc2, t2;
    logic [9:0]  ia2;
    logic [19:0] pc2;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [8:0] sb[$];
    int         acc_q[$];

    logic        s_acc, s_got, s_l, s_ov, s_ir;
    logic [7:0]  s_t;
    logic [19:0] s_pc;
    int          s_cyc;

    te_transmission_estimator dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Fc        (Fc),
        .Inv_Ac    (Inv_Ac),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .T         (T),
        .out_last  (out_last),
        .pix_count (pix_count)
    );

    te_transmission_estimator #(
        .T0_MIN (8'd0)
    ) dut_z (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (iv2),
        .in_ready  (ir2),
        .Fc        (fc2),
        .Inv_Ac    (ia2),
        .in_last   (il2),
        .out_valid (ov2),
        .out_ready (or2),
        .T         (t2),
        .out_last  (ol2),
        .pix_count (pc2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [8:0] model(input int fc, input int ia,
                                         input int om, input int t0,
                                         input logic last);
        int r;
        int t;
        r = (fc * ia * om) / 65536;
        if (r > 255) r = 255;
        t = 255 - r;
        if (t < t0) t = t0;
        return {t[7:0], last};
    endfunction

    // One clock: drive at negedge, sample just after, push accepted pixels.
    task automatic tick(input logic r, input logic iv, input logic [7:0] fc,
                        input logic [9:0] ia, input logic il, input logic ordy);
        @(negedge clk);
        rst       = r;
        in_valid  = iv;
        Fc        = fc;
        Inv_Ac    = ia;
        in_last   = il;
        out_ready = ordy;
        #1;
        s_acc = iv && in_ready;
        s_got = out_valid && out_ready;
        s_t   = T;
        s_l   = out_last;
        s_ov  = out_valid;
        s_ir  = in_ready;
        s_pc  = pix_count;
        s_cyc = cyc;
        if (s_acc) begin
            sb.push_back(model(fc, ia, OMEGA_V, T0_V, il));
            acc_q.push_back(cyc);
        end
        cyc++;
        @(posedge clk);
    endtask

    task automatic test_reset();
        tick(1, 0, 0, 0, 0, 1);
        tick(1, 0, 0, 0, 0, 1);
        tick(1, 0, 0, 0, 0, 1);
        checks++;
        if ({s_ov, s_t, s_l, s_pc} !== 30'd0) begin
            errors++;
            $display("FAIL reset_state: ov=%0b T=%0d last=%0b pc=%0d, need all 0",
                     s_ov, s_t, s_l, s_pc);
        end
        checks++;
        if (s_ir !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_ready: got %0b need 0", s_ir);
        end
        tick(0, 0, 0, 0, 0, 1);
        checks++;
        if (s_ir !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_in_ready: got %0b need 1", s_ir);
        end
    endtask

    task automatic test_single(input logic [7:0] fc, input logic [9:0] ia,
                               input logic [7:0] t_const, input string nm);
        logic [8:0] e;
        int lat;
        bit seen;
        seen = 0;
        tick(0, 1, fc, ia, 0, 1);
        for (int i = 0; i < 10 && !seen; i++) begin
            tick(0, 0, 0, 0, 0, 1);
            if (s_got) begin
                seen = 1;
                e    = sb.pop_front();
                lat  = s_cyc - acc_q.pop_front();
                checks++;
                if ({s_t, s_l} !== e || s_t !== t_const) begin
                    errors++;
                    $display("FAIL %s_value: T=%0d last=%0b need T=%0d last=%0b",
                             nm, s_t, s_l, t_const, e[0]);
                end
                checks++;
                if (lat != 3) begin
                    errors++;
                    $display("FAIL %s_latency: got %0d need 3", nm, lat);
                end
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_timeout: no output, need 1", nm);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] got_t[$];
        int         got_c[$];
        logic [8:0] e;
        tick(0, 1, 8'd200, 10'd300, 0, 1);
        tick(0, 1, 8'd100, 10'd512, 0, 1);
        for (int i = 0; i < 10; i++) begin
            tick(0, 0, 0, 0, 0, 1);
            if (s_got && sb.size() > 0) begin
                e = sb.pop_front();
                void'(acc_q.pop_front());
                checks++;
                if ({s_t, s_l} !== e) begin
                    errors++;
                    $display("FAIL b2b_model: T=%0d need %0d", s_t, e[8:1]);
                end
                got_t.push_back(s_t);
                got_c.push_back(s_cyc);
            end
        end
        checks++;
        if (got_t.size() != 2) begin
            errors++;
            $display("FAIL b2b_count: got %0d need 2", got_t.size());
        end else begin
            checks++;
            if (got_t[0] !== 8'd33 || got_t[1] !== 8'd66) begin
                errors++;
                $display("FAIL b2b_order: got %0d,%0d need 33,66", got_t[0], got_t[1]);
            end
            checks++;
            if (got_c[1] - got_c[0] != 1) begin
                errors++;
                $display("FAIL b2b_gap: got %0d cycles need 1", got_c[1] - got_c[0]);
            end
        end
    endtask

    task automatic test_t0_zero();
        bit seen;
        int n;
        seen = 0;
        n    = 0;
        @(negedge clk);
        iv2 = 1'b1;
        fc2 = 8'd255;
        ia2 = 10'd1023;
        #1;
        checks++;
        if (ir2 !== 1'b1) begin
            errors++;
            $display("FAIL t0z_in_ready: got %0b need 1", ir2);
        end
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            iv2 = 1'b0;
            n++;
            #1;
            if (ov2) begin
                seen = 1;
                checks++;
                if (t2 !== 8'd0 || n != 3) begin
                    errors++;
                    $display("FAIL t0z_value: T=%0d after %0d cycles need T=0 after 3",
                             t2, n);
                end
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL t0z_timeout: no output, need 1");
        end
    endtask

    task automatic test_backpressure();
        logic [8:0] e;
        logic [7:0] held;
        int         rx;
        rx = 0;
        held = 8'd0;
        for (int i = 0; i < 30; i++) begin
            if (i < 5) begin
                tick(0, 1, 8'($urandom_range(0, 255)),
                     10'($urandom_range(0, 1023)), 0, 1);
            end else if (i < 9) begin
                tick(0, 1, 8'd77, 10'd99, 0, 0);
                if (i == 5) held = s_t;
                checks++;
                if (s_ir !== 1'b0 || s_ov !== 1'b1 || s_t !== held) begin
                    errors++;
                    $display("FAIL bp_stall: ir=%0b ov=%0b T=%0d need ir=0 ov=1 T=%0d",
                             s_ir, s_ov, s_t, held);
                end
            end else begin
                tick(0, 0, 0, 0, 0, 1);
            end
            if (s_got) begin
                rx++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL bp_extra: T=%0d with empty scoreboard", s_t);
                end else begin
                    e = sb.pop_front();
                    void'(acc_q.pop_front());
                    checks++;
                    if ({s_t, s_l} !== e) begin
                        errors++;
                        $display("FAIL bp_order: T=%0d need %0d", s_t, e[8:1]);
                    end
                end
            end
        end
        checks++;
        if (rx != 5 || sb.size() != 0) begin
            errors++;
            $display("FAIL bp_count: got %0d outputs need 5, left %0d", rx, sb.size());
        end
    endtask

    task automatic test_frame();
        logic [8:0] e;
        int         k;
        k = 0;
        tick(1, 0, 0, 0, 0, 1);
        for (int i = 0; i < 20; i++) begin
            if (i < 7) begin
                tick(0, 1, 8'(i * 30), 10'(100 + i * 50), (i == 6), 1);
            end else begin
                tick(0, 0, 0, 0, 0, 1);
            end
            if (s_got && sb.size() > 0) begin
                e = sb.pop_front();
                void'(acc_q.pop_front());
                checks++;
                if ({s_t, s_l} !== e || s_l !== (k == 6)) begin
                    errors++;
                    $display("FAIL frame_pix%0d: T=%0d last=%0b need T=%0d last=%0b",
                             k, s_t, s_l, e[8:1], (k == 6));
                end
                checks++;
                if (s_pc !== 20'(k)) begin
                    errors++;
                    $display("FAIL frame_count%0d: got %0d need %0d", k, s_pc, k);
                end
                k++;
            end
        end
        checks++;
        if (k != 7 || s_pc !== 20'd0) begin
            errors++;
            $display("FAIL frame_end: outputs=%0d pc=%0d need 7 and 0", k, s_pc);
        end
    endtask

    task automatic test_reset_midflight();
        logic [8:0] e;
        int  lat;
        bit  seen;
        seen = 0;
        tick(0, 1, 8'd10, 10'd20, 0, 0);
        tick(0, 1, 8'd30, 10'd40, 0, 0);
        tick(0, 1, 8'd50, 10'd60, 0, 0);
        tick(1, 0, 0, 0, 0, 0);
        sb.delete();
        acc_q.delete();
        tick(0, 0, 0, 0, 0, 1);
        checks++;
        if (s_ov !== 1'b0 || s_pc !== 20'd0) begin
            errors++;
            $display("FAIL midrst_state: ov=%0b pc=%0d need 0 and 0", s_ov, s_pc);
        end
        for (int i = 0; i < 5; i++) begin
            tick(0, 0, 0, 0, 0, 1);
            if (s_got) begin
                checks++;
                errors++;
                $display("FAIL midrst_ghost: T=%0d need no output", s_t);
            end
        end
        tick(0, 1, 8'd200, 10'd300, 0, 1);
        for (int i = 0; i < 10 && !seen; i++) begin
            tick(0, 0, 0, 0, 0, 1);
            if (s_got) begin
                seen = 1;
                e    = sb.pop_front();
                lat  = s_cyc - acc_q.pop_front();
                checks++;
                if ({s_t, s_l} !== e || lat != 3) begin
                    errors++;
                    $display("FAIL midrst_new: T=%0d lat=%0d need T=%0d lat=3",
                             s_t, lat, e[8:1]);
                end
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL midrst_timeout: no output, need 1");
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_last = 1'b0;
        Fc = '0;
        Inv_Ac = '0;
        out_ready = 1'b1;
        iv2 = 1'b0;
        il2 = 1'b0;
        fc2 = '0;
        ia2 = '0;
        or2 = 1'b1;
        test_reset();
        test_single(8'd0, 10'd256, 8'd255, "zero");
        test_back_to_back();
        test_single(8'd255, 10'd1023, 8'd26, "sat");
        test_t0_zero();
        test_backpressure();
        test_frame();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
